regfile_stream_ctrl: RTL and testbench
======================================

// Module: regfile_stream_ctrl
// PURPOSE
//  Initiator for the 32x32 register file: bulk-loads a run of registers from an input word stream
//  (LOAD) or streams a run out through read port A (DUMP), each via valid/ready handshakes.
//  Sits between the host/message-block loader and the regfile.
//  Owns the regfile write port and read port A while busy.
// PARAMETERS
//  NUM_REGS  32  registers in the regfile; the address pointer wraps modulo NUM_REGS
//  ADDR_W    5   register address width, log2(NUM_REGS)
//  DATA_W    32  word width
// PORTS
//  clock            in   1       single clock; all state updates on the rising edge
//  ctrl_reset_n     in   1       reset, synchronous, active-low
//  cmd_valid        in   1       command offered
//  cmd_ready        out  1       command accepted when cmd_valid&&cmd_ready
//  cmd_op           in   1       0=LOAD, 1=DUMP
//  cmd_base         in   ADDR_W  first register of the run
//  cmd_count        in   ADDR_W+1  words in the run; legal range 1..NUM_REGS
//  in_valid/in_ready  in/out  1  LOAD word stream handshake
//  in_data          in   DATA_W  LOAD word
//  out_valid/out_ready out/in 1  DUMP word stream handshake
//  out_data         out  DATA_W  DUMP word
//  busy             out  1       high from command accept until done
//  done             out  1       one-cycle pulse when a run completes
//  err              out  1       one-cycle pulse when an illegal command is rejected
//  rf_writeEnable   out  1       to regfile ctrl_writeEnable
//  rf_writeReg      out  ADDR_W  to regfile ctrl_writeReg
//  rf_writeData     out  DATA_W  to regfile data_writeReg
//  rf_readReg       out  ADDR_W  to regfile ctrl_readRegA
//  rf_readData      in   DATA_W  from regfile data_readRegA (combinational read)
// BEHAVIOUR
//  - Reset: every output 0 and FSM=IDLE at the first rising edge with ctrl_reset_n=0. Reset mid-run
//    aborts the run: writes already committed stay; no done pulse; out_valid drops.
//  - FSM states: IDLE -> LOAD | DUMP -> FIN -> IDLE.
//  - IDLE: cmd_ready=1.
//    On accept, ptr<=cmd_base and rem<=cmd_count.
//    If cmd_count==0 or cmd_count>NUM_REGS: err pulses next cycle and the FSM stays IDLE.
//  - LOAD: in_ready=1 while rem!=0.
//    Each in handshake registers rf_writeEnable=1, rf_writeReg=ptr, rf_writeData=in_data for exactly
//    the next cycle; the regfile commits on that cycle's falling edge.
//    Then ptr<=ptr+1 mod NUM_REGS and rem<=rem-1.
//    Throughput 1 word/cycle. rf_writeEnable is 0 in every other cycle.
//    Writes to r0 are still issued; the regfile discards them.
//  - DUMP: rf_readReg=ptr combinationally.
//    When (!out_valid || out_ready) && rem!=0: out_data<=rf_readData, out_valid<=1, ptr++, rem--.
//    When out_valid && out_ready && rem==0: out_valid<=0.
//    While out_valid && !out_ready, out_data is held stable. Throughput 1 word/cycle.
//  - FSM leaves LOAD when rem==0 and the last write cycle has been driven.
//    FSM leaves DUMP on the last out handshake.
//    FIN: done=1 for one cycle, busy=0 from the next cycle, then IDLE.
//  - busy=1 in LOAD, DUMP and FIN.
//    cmd_ready=0 while busy, so a DUMP that follows a LOAD always sees the committed data.
//  - Wrap-around: base=30, count=4 touches r30, r31, r0, r1.
//  - in_valid in IDLE/DUMP and out_ready in IDLE/LOAD are ignored.
// STRUCTURE
//  - Shared package regfile_pkg holds:
//    - constants NUM_REGS, ADDR_W, DATA_W;
//    - the op encoding typedef (OP_LOAD, OP_DUMP);
//    - the FSM state typedef.
//  - Sub-module regfile_run_counter holds ptr (wrapping) and rem, with load/step/zero-flag.
//    The top level holds the FSM and the output registers.
// TESTING
//  1. LOAD base=1 count=3 with words A,B,C on back-to-back cycles.
//     Required: rf_writeEnable high 3 consecutive cycles with rf_writeReg 1,2,3; done pulses once;
//     a regfile model reads A,B,C.
//  2. DUMP base=1 count=3 after test 1 with out_ready=1.
//     Required: out_data A,B,C on consecutive cycles; done pulses once; busy=0 afterwards.
//  3. DUMP with out_ready toggled 1,0,0,1,...
//     Required: out_data stable while stalled; no word lost or duplicated; order preserved.
//  4. LOAD base=30 count=4.
//     Required: rf_writeReg sequence 30,31,0,1; the regfile shows r0 still 0.
//  5. Commands with cmd_count=0 and cmd_count=33.
//     Required: err pulses once for each; busy stays 0; no rf_writeEnable.
//  6. Assert ctrl_reset_n=0 after 2 of 5 LOAD words.
//     Required: all outputs 0 on the next edge; first 2 registers written and the rest untouched;
//     no done pulse; a new command is accepted after reset is released.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file stream controller slice.
//   NUM_REGS / ADDR_W / DATA_W : regfile geometry
//   op_e                       : command opcode (LOAD streams words in, DUMP streams words out)
//   state_e                    : controller FSM states
package regfile_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_DUMP = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_run_counter.sv
// Run counter for the stream controller: register pointer (wrapping modulo NUM_REGS)
// plus words-remaining count.
//   clk_i    in   clock, rising edge
//   rst_ni   in   synchronous active-low reset
//   load_i   in   load ptr<=base_i, rem<=count_i (takes priority over step_i)
//   base_i   in   first register of the run
//   count_i  in   number of words in the run
//   step_i   in   advance ptr and decrement rem (ignored when rem is already 0)
//   ptr_o    out  current register pointer
//   zero_o   out  rem == 0
module regfile_run_counter #(
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   count_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              zero_o
);

    import regfile_pkg::*;

    localparam int unsigned RW = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;

    always_comb begin
        ptr_d = ptr_q;
        rem_d = rem_q;
        if (load_i) begin
            ptr_d = base_i;
            rem_d = count_i;
        end else if (step_i && (rem_q != '0)) begin
            // Explicit wrap so a non power-of-two NUM_REGS still stays in range.
            ptr_d = (ptr_q == LAST_REG) ? '0 : ptr_q + ADDR_W'(1);
            rem_d = rem_q - RW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            rem_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign zero_o = (rem_q == '0);

endmodule

// File: rtl/regfile_stream_ctrl.sv
// Register-file stream controller. Bulk-loads a run of registers from an input word
// stream (LOAD) or streams a run out through read port A (DUMP). Owns the regfile write
// port and read port A while busy.
//   clock, ctrl_reset_n            clock (rising edge) and synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake; cmd_op (0=LOAD,1=DUMP), cmd_base, cmd_count
//   in_valid/in_ready/in_data      LOAD word stream
//   out_valid/out_ready/out_data   DUMP word stream
//   busy, done, err                status: busy during a run, done/err one-cycle pulses
//   rf_writeEnable/Reg/Data        regfile write port (registered, commits on falling edge)
//   rf_readReg/rf_readData         regfile read port A (combinational read)
module regfile_stream_ctrl #(
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rf_writeEnable,
    output logic [ADDR_W-1:0] rf_writeReg,
    output logic [DATA_W-1:0] rf_writeData,
    output logic [ADDR_W-1:0] rf_readReg,
    input  logic [DATA_W-1:0] rf_readData
);

    import regfile_pkg::*;

    localparam int unsigned CW = ADDR_W + 1;
    localparam logic [ADDR_W:0] MAX_COUNT = CW'(NUM_REGS);

    state_e state_q, state_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              err_q, err_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_wreg_q, rf_wreg_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              cnt_load;
    logic              cnt_step;
    logic [ADDR_W-1:0] ptr;
    logic              rem_zero;

    logic              cmd_accept;
    logic              cmd_legal;
    logic              in_hs;

    regfile_run_counter #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_run_counter (
        .clk_i   (clock),
        .rst_ni  (ctrl_reset_n),
        .load_i  (cnt_load),
        .base_i  (cmd_base),
        .count_i (cmd_count),
        .step_i  (cnt_step),
        .ptr_o   (ptr),
        .zero_o  (rem_zero)
    );

    assign cmd_accept = cmd_valid && cmd_ready_q;
    assign cmd_legal  = (cmd_count != '0) && (cmd_count <= MAX_COUNT);
    assign in_ready   = (state_q == ST_LOAD) && !rem_zero;
    assign in_hs      = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        err_d       = 1'b0;
        rf_we_d     = 1'b0;
        rf_wreg_d   = rf_wreg_q;
        rf_wdata_d  = rf_wdata_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cnt_load    = 1'b0;
        cnt_step    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    // The counter is loaded even for an illegal command; it is unused until
                    // the next legal accept reloads it.
                    cnt_load = 1'b1;
                    if (!cmd_legal) begin
                        err_d = 1'b1;
                    end else if (op_e'(cmd_op) == OP_DUMP) begin
                        state_d = ST_DUMP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (in_hs) begin
                    rf_we_d    = 1'b1;
                    rf_wreg_d  = ptr;
                    rf_wdata_d = in_data;
                    cnt_step   = 1'b1;
                end else if (rem_zero) begin
                    // rem reaches 0 on the edge that registers the last write, so this is
                    // the cycle in which that final write is driven.
                    state_d = ST_FIN;
                end
            end
            ST_DUMP: begin
                if ((!out_valid_q || out_ready) && !rem_zero) begin
                    out_data_d  = rf_readData;
                    out_valid_d = 1'b1;
                    cnt_step    = 1'b1;
                end else if (out_valid_q && out_ready && rem_zero) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so that cmd_ready reads 0 throughout reset.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            err_q       <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_wreg_q   <= '0;
            rf_wdata_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            err_q       <= err_d;
            rf_we_q     <= rf_we_d;
            rf_wreg_q   <= rf_wreg_d;
            rf_wdata_q  <= rf_wdata_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign err            = err_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FIN);
    assign rf_writeEnable = rf_we_q;
    assign rf_writeReg    = rf_wreg_q;
    assign rf_writeData   = rf_wdata_q;
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign rf_readReg     = (state_q == ST_DUMP) ? ptr : '0;

endmodule

// File: tb/tb_regfile_stream_ctrl.sv
// Self-checking bench for regfile_stream_ctrl with a falling-edge-commit regfile model
// and an array-based reference of expected register contents.
module tb_regfile_stream_ctrl;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [4:0]  cmd_base;
    logic [5:0]  cmd_count;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        rf_writeEnable;
    logic [4:0]  rf_writeReg;
    logic [31:0] rf_writeData;
    logic [4:0]  rf_readReg;
    logic [31:0] rf_readData;

    regfile_stream_ctrl #(
        .NUM_REGS (32),
        .ADDR_W   (5),
        .DATA_W   (32)
    ) dut (
        .clock          (clock),
        .ctrl_reset_n   (ctrl_reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_base       (cmd_base),
        .cmd_count      (cmd_count),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .rf_writeEnable (rf_writeEnable),
        .rf_writeReg    (rf_writeReg),
        .rf_writeData   (rf_writeData),
        .rf_readReg     (rf_readReg),
        .rf_readData    (rf_readData)
    );

    always #5 clock = ~clock;

    // Regfile model: commit on the falling edge, r0 hard-wired to zero.
    logic [31:0] mem [32] = '{default: '0};
    always @(negedge clock) begin
        if (rf_writeEnable && (rf_writeReg != 5'd0)) mem[rf_writeReg] <= rf_writeData;
    end
    assign rf_readData = (rf_readReg == 5'd0) ? 32'd0 : mem[rf_readReg];

    // Event recorder (observations only; all comparisons happen in the initial block).
    int unsigned cyc = 0;
    int unsigned wr_reg_q  [$];
    logic [31:0] wr_data_q [$];
    int unsigned wr_cyc_q  [$];
    logic [31:0] out_q     [$];
    int unsigned out_cyc_q [$];
    int unsigned done_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned busy_cnt = 0;
    int unsigned stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    always @(posedge clock) cyc = cyc + 1;

    always @(negedge clock) begin
        if (rf_writeEnable === 1'b1) begin
            wr_reg_q.push_back(int'(rf_writeReg));
            wr_data_q.push_back(rf_writeData);
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            out_q.push_back(out_data);
            out_cyc_q.push_back(cyc);
        end
        if (prev_stall && out_valid === 1'b1 && out_data !== prev_data) stall_viol++;
        prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
        prev_data  = out_data;
    end

    // Reference model state.
    logic [31:0] exp_mem [32];
    logic [31:0] wbuf [32];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned timeouts = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [95:0] outs_vec();
        return {15'd0, cmd_ready, in_ready, out_valid, out_data, busy, done, err,
                rf_writeEnable, rf_writeReg, rf_writeData, rf_readReg};
    endfunction

    task automatic model_load(input int unsigned base, input int unsigned nwritten);
        for (int unsigned i = 0; i < nwritten; i++) begin
            if (((base + i) % 32) != 0) exp_mem[(base + i) % 32] = wbuf[i];
        end
    endtask

    task automatic send_cmd(input logic op, input int unsigned base, input int unsigned count,
                            input string tag);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = 5'(base);
        cmd_count = 6'(count);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic load_words(input int unsigned n, input bit gaps);
        for (int unsigned i = 0; i < n; i++) begin
            int k = 0;
            logic rdy;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = wbuf[i];
            do begin
                rdy = in_ready;
                tick();
                k++;
            end while (rdy !== 1'b1 && k < 100);
            if (rdy !== 1'b1) timeouts++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic load_run(input int unsigned base, input int unsigned count, input bit gaps,
                            input string tag);
        int unsigned w0 = wr_reg_q.size();
        int unsigned d0 = done_cnt;
        int unsigned t0 = timeouts;
        send_cmd(1'b0, base, count, tag);
        load_words(count, gaps);
        wait_idle(tag);
        model_load(base, count);
        check({tag, "_timeouts"}, timeouts - t0, 0);
        check({tag, "_nwrites"}, wr_reg_q.size() - w0, count);
        if (wr_reg_q.size() - w0 == count) begin
            for (int unsigned i = 0; i < count; i++) begin
                check($sformatf("%s_wreg%0d", tag, i), wr_reg_q[w0 + i], (base + i) % 32);
                check($sformatf("%s_wdata%0d", tag, i), wr_data_q[w0 + i], wbuf[i]);
                if (!gaps)
                    check($sformatf("%s_wcyc%0d", tag, i), wr_cyc_q[w0 + i], wr_cyc_q[w0] + i);
            end
        end
        check({tag, "_done"}, done_cnt - d0, 1);
    endtask

    task automatic dump_run(input int unsigned base, input int unsigned count, input bit stall,
                            input string tag);
        int unsigned o0 = out_q.size();
        int unsigned d0 = done_cnt;
        int unsigned s0 = stall_viol;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int n = 0;
        send_cmd(1'b1, base, count, tag);
        while (busy === 1'b1 && n < 300) begin
            out_ready = stall ? pat[n % 4] : 1'b1;
            tick();
            n++;
        end
        out_ready = 1'b0;
        check({tag, "_idle"}, busy, 0);
        check({tag, "_nwords"}, out_q.size() - o0, count);
        if (out_q.size() - o0 == count) begin
            for (int unsigned i = 0; i < count; i++) begin
                check($sformatf("%s_data%0d", tag, i), out_q[o0 + i], exp_mem[(base + i) % 32]);
                if (!stall)
                    check($sformatf("%s_cyc%0d", tag, i), out_cyc_q[o0 + i], out_cyc_q[o0] + i);
            end
        end
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_stall_stable"}, stall_viol - s0, 0);
    endtask

    initial begin
        int unsigned e0, b0, w0, d0, rbase, rcount;

        ctrl_reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_base  = '0;
        cmd_count = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;

        repeat (3) tick();
        check("reset_outputs", outs_vec(), 96'd0);
        ctrl_reset_n = 1'b1;

        // LOAD r1..r3 back-to-back, then read the regfile model.
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        load_run(1, 3, 1'b0, "t1");
        for (int i = 0; i < 3; i++) check($sformatf("t1_rf%0d", i + 1), mem[i + 1], wbuf[i]);

        // DUMP the same run with out_ready held high.
        dump_run(1, 3, 1'b0, "t2");

        // Random LOAD with input gaps, then a full 32-word DUMP with stalls.
        rbase  = $urandom_range(0, 31);
        rcount = $urandom_range(1, 32);
        for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
        load_run(rbase, rcount, 1'b1, "t3_load");
        dump_run($urandom_range(0, 31), 32, 1'b1, "t3_dump");

        // Wrap-around LOAD, then read it back (r0 must read as zero).
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom | 32'h1;
        load_run(30, 4, 1'b0, "t4");
        dump_run(30, 4, 1'b1, "t4_dump");

        // Illegal counts.
        e0 = err_cnt;
        b0 = busy_cnt;
        w0 = wr_reg_q.size();
        send_cmd(1'b0, 5, 0, "t5_zero");
        tick();
        check("t5_err_zero", err_cnt - e0, 1);
        send_cmd(1'b1, 5, 33, "t5_big");
        tick();
        check("t5_err_big", err_cnt - e0, 2);
        check("t5_busy", busy_cnt - b0, 0);
        check("t5_nowrite", wr_reg_q.size() - w0, 0);

        // Reset after 2 of 5 LOAD words.
        for (int i = 0; i < 5; i++) wbuf[i] = $urandom;
        w0 = wr_reg_q.size();
        d0 = done_cnt;
        send_cmd(1'b0, 10, 5, "t6");
        load_words(2, 1'b0);
        in_valid = 1'b1;
        in_data  = wbuf[2];
        ctrl_reset_n = 1'b0;
        tick();
        check("t6_reset_outputs", outs_vec(), 96'd0);
        in_valid = 1'b0;
        tick();
        ctrl_reset_n = 1'b1;
        model_load(10, 2);
        check("t6_nwrites", wr_reg_q.size() - w0, 2);
        check("t6_done", done_cnt - d0, 0);
        dump_run(10, 5, 1'b0, "t6_dump");

        // Whole regfile against the reference.
        for (int i = 1; i < 32; i++) check($sformatf("final_r%0d", i), mem[i], exp_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
